// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : EX/MEM -> MEM/WB bundle for the memory pipeline stage.
//               master : upstream/driver side (drives in_*, flush; sees stall,
//                        out_*)
//               slave  : the memory stage itself
//               Ports  : in_valid, in_rf_write, in_memtoreg, in_dm_write,
//                        in_fwd_sel, in_store_data, in_fwd_data, in_result,
//                        in_rs1, in_rs2, in_rd, in_branch, flush (to stage);
//                        stall, out_valid, out_rf_write, out_memtoreg,
//                        out_result, out_dm_data, out_rs1, out_rs2, out_rd,
//                        out_branch (from stage)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
);
    logic              in_valid;
    logic              in_rf_write;
    logic              in_memtoreg;
    logic              in_dm_write;
    logic              in_fwd_sel;
    logic [DATA_W-1:0] in_store_data;
    logic [DATA_W-1:0] in_fwd_data;
    logic [DATA_W-1:0] in_result;
    logic [REG_W-1:0]  in_rs1;
    logic [REG_W-1:0]  in_rs2;
    logic [REG_W-1:0]  in_rd;
    logic [2:0]        in_branch;
    logic              flush;

    logic              stall;
    logic              out_valid;
    logic              out_rf_write;
    logic              out_memtoreg;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_dm_data;
    logic [REG_W-1:0]  out_rs1;
    logic [REG_W-1:0]  out_rs2;
    logic [REG_W-1:0]  out_rd;
    logic [2:0]        out_branch;

    modport master (
        output in_valid, in_rf_write, in_memtoreg, in_dm_write, in_fwd_sel,
               in_store_data, in_fwd_data, in_result, in_rs1, in_rs2, in_rd,
               in_branch, flush,
        input  stall, out_valid, out_rf_write, out_memtoreg, out_result,
               out_dm_data, out_rs1, out_rs2, out_rd, out_branch
    );

    modport slave (
        input  in_valid, in_rf_write, in_memtoreg, in_dm_write, in_fwd_sel,
               in_store_data, in_fwd_data, in_result, in_rs1, in_rs2, in_rd,
               in_branch, flush,
        output stall, out_valid, out_rf_write, out_memtoreg, out_result,
               out_dm_data, out_rs1, out_rs2, out_rd, out_branch
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pipe
// Description : Pipeline MEM stage with a multi-cycle data memory. A memory
//               op (load or store) holds the stage for MEM_LAT cycles, raising
//               stall and inserting bubbles into MEM/WB until the access
//               completes. Non-memory ops pass straight through in one cycle.
//               Ports: clk, rst (sync, active-high), bus (mem_stage_if.slave).
//               Option macro MEM_STAGE_STORE_FWD_EN: when defined, store data
//               may be taken from the WB forwarding path (in_fwd_sel).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_pipe #(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH_LOG2 = 8,
    parameter int MEM_LAT    = 3    // legal range 1..8
) (
    input  wire        clk,
    input  wire        rst,
    mem_stage_if.slave bus
);
    localparam int c_CNT_W = $clog2(MEM_LAT) + 1;
    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    // First BUSY cycle loads MEM_LAT-2 so that IDLE + BUSY cycles = MEM_LAT.
    localparam logic [c_CNT_W-1:0] c_CNT_INIT =
        c_CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic                w_stall;
    logic                w_load;      // MEM/WB captures inputs (else bubble)
    logic                w_complete;  // memory access finishes this cycle
    logic                w_mem_op;
    logic [DEPTH_LOG2-1:0] w_addr;
    logic [DATA_W-1:0]   w_store_data;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];

    logic                r_valid, r_rf_write, r_memtoreg;
    logic [DATA_W-1:0]   r_result, r_dm_data;
    logic [REG_W-1:0]    r_rs1, r_rs2, r_rd;
    logic [2:0]          r_branch;

    assign w_mem_op = bus.in_valid & (bus.in_memtoreg | bus.in_dm_write);
    // Upper address bits are intentionally dropped: the array aliases.
    assign w_addr   = bus.in_result[DEPTH_LOG2-1:0];

`ifdef MEM_STAGE_STORE_FWD_EN
    assign w_store_data = bus.in_fwd_sel ? bus.in_fwd_data : bus.in_store_data;
`else
    assign w_store_data = bus.in_store_data;
    logic w_unused_fwd;
    assign w_unused_fwd = bus.in_fwd_sel ^ (^bus.in_fwd_data);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_load      = 1'b0;
        w_complete  = 1'b0;
        if (rst) begin
            // Keep stall low and suppress any store while in reset.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (bus.flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_mem_op) begin
                        w_load = 1'b1;
                    end else if (MEM_LAT == 1) begin
                        w_load     = 1'b1;
                        w_complete = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        w_stall   = 1'b1;
                        w_cnt_nxt = r_cnt - c_CNT_W'(1);
                    end else begin
                        w_load      = 1'b1;
                        w_complete  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_rf_write <= 1'b0;
            r_memtoreg <= 1'b0;
            r_result   <= '0;
            r_dm_data  <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_branch   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_valid    <= bus.in_valid;
                r_rf_write <= bus.in_rf_write;
                r_memtoreg <= bus.in_memtoreg;
                r_result   <= bus.in_result;
                r_rs1      <= bus.in_rs1;
                r_rs2      <= bus.in_rs2;
                r_rd       <= bus.in_rd;
                r_branch   <= bus.in_branch;
                if (w_complete && bus.in_memtoreg) begin
                    r_dm_data <= r_mem[w_addr];
                end
            end else begin
                // Bubble: only the control bits are cleared.
                r_valid    <= 1'b0;
                r_rf_write <= 1'b0;
                r_memtoreg <= 1'b0;
            end
        end
    end

    // Array is not reset; w_complete is already forced low during rst/flush.
    always_ff @(posedge clk) begin
        if (w_complete && bus.in_dm_write) begin
            r_mem[w_addr] <= w_store_data;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.out_valid    = r_valid;
    assign bus.out_rf_write = r_rf_write;
    assign bus.out_memtoreg = r_memtoreg;
    assign bus.out_result   = r_result;
    assign bus.out_dm_data  = r_dm_data;
    assign bus.out_rs1      = r_rs1;
    assign bus.out_rs2      = r_rs2;
    assign bus.out_rd       = r_rd;
    assign bus.out_branch   = r_branch;
endmodule
`default_nettype wire

// File: tb/tb_mem_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_pipe
// Description : Directed self-checking bench for mem_stage_pipe. Instance A
//               uses MEM_LAT=3, instance B uses MEM_LAT=1. Expected store
//               data in the forwarding case follows MEM_STAGE_STORE_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_if #(.DATA_W(16), .REG_W(4)) bus_a ();
    mem_stage_if #(.DATA_W(16), .REG_W(4)) bus_b ();

    mem_stage_pipe #(.DATA_W(16), .REG_W(4), .DEPTH_LOG2(8), .MEM_LAT(3)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );
    mem_stage_pipe #(.DATA_W(16), .REG_W(4), .DEPTH_LOG2(8), .MEM_LAT(1)) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic rfw, input logic m2r, input logic dmw,
                           input logic fsel, input logic [15:0] sd, input logic [15:0] fd,
                           input logic [15:0] res, input logic [3:0] rs1, input logic [3:0] rs2,
                           input logic [3:0] rd, input logic [2:0] br);
        bus_a.in_valid      = v;
        bus_a.in_rf_write   = rfw;
        bus_a.in_memtoreg   = m2r;
        bus_a.in_dm_write   = dmw;
        bus_a.in_fwd_sel    = fsel;
        bus_a.in_store_data = sd;
        bus_a.in_fwd_data   = fd;
        bus_a.in_result     = res;
        bus_a.in_rs1        = rs1;
        bus_a.in_rs2        = rs2;
        bus_a.in_rd         = rd;
        bus_a.in_branch     = br;
    endtask

    // Hold inputs until stall drops, then take the completion edge.
    // mid_* snapshot the outputs during the second stall cycle (bubble).
    task automatic step_a(output int stalls, output logic mid_valid, output logic [15:0] mid_result);
        stalls     = 0;
        mid_valid  = 1'b1;
        mid_result = 16'h0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!bus_a.stall) break;
            stalls++;
            if (stalls >= 2) begin
                mid_valid  = bus_a.out_valid;
                mid_result = bus_a.out_result;
            end
            tick();
        end
        if (bus_a.stall) check("stall_bound", bus_a.stall, 1'b0);
        tick();
    endtask

    int          st;
    logic        mv;
    logic [15:0] mr;
    logic [15:0] exp_fwd;

    initial begin
        bus_a.flush = 1'b0;
        bus_b.flush = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_rf_write = 1'b0; bus_b.in_memtoreg = 1'b0;
        bus_b.in_dm_write = 1'b0; bus_b.in_fwd_sel = 1'b0; bus_b.in_store_data = '0;
        bus_b.in_fwd_data = '0; bus_b.in_result = '0; bus_b.in_rs1 = '0;
        bus_b.in_rs2 = '0; bus_b.in_rd = '0; bus_b.in_branch = '0;

        // Reset with a memory op presented: stall must stay low.
        rst = 1'b1;
        drive_a(1, 0, 0, 1, 0, 16'hFFFF, 0, 16'h0044, 0, 0, 0, 0);
        tick(); tick();
        check("rst_stall", bus_a.stall, 1'b0);
        check("rst_valid", bus_a.out_valid, 1'b0);
        check("rst_result", bus_a.out_result, 16'h0);
        check("rst_dm_data", bus_a.out_dm_data, 16'h0);
        check("rst_rd", bus_a.out_rd, 4'h0);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // ALU op passes through in one cycle.
        drive_a(1, 1, 0, 0, 0, 0, 0, 16'h1234, 4'd1, 4'd2, 4'd5, 3'b101);
        step_a(st, mv, mr);
        check("alu_stalls", st, 0);
        check("alu_result", bus_a.out_result, 16'h1234);
        check("alu_rd", bus_a.out_rd, 4'd5);
        check("alu_valid", bus_a.out_valid, 1'b1);
        check("alu_rf_write", bus_a.out_rf_write, 1'b1);
        check("alu_rs1", bus_a.out_rs1, 4'd1);
        check("alu_branch", bus_a.out_branch, 3'b101);

        // Store 0xBEEF to 0x0012, then load it back immediately.
        drive_a(1, 0, 0, 1, 0, 16'hBEEF, 16'h0, 16'h0012, 0, 0, 0, 0);
        step_a(st, mv, mr);
        check("st_stalls", st, 2);
        check("st_valid", bus_a.out_valid, 1'b1);
        check("st_result", bus_a.out_result, 16'h0012);
        check("st_rf_write", bus_a.out_rf_write, 1'b0);
        drive_a(1, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0012, 0, 0, 4'd3, 0);
        step_a(st, mv, mr);
        check("ld_stalls", st, 2);
        check("ld_bubble_valid", mv, 1'b0);
        check("ld_bubble_result", mr, 16'h0012);
        check("ld_dm_data", bus_a.out_dm_data, 16'hBEEF);
        check("ld_valid", bus_a.out_valid, 1'b1);
        check("ld_memtoreg", bus_a.out_memtoreg, 1'b1);
        check("ld_rd", bus_a.out_rd, 4'd3);

        // Address wrap: 0x0105 aliases to 0x0005.
        drive_a(1, 0, 0, 1, 0, 16'hA5A5, 16'h0, 16'h0105, 0, 0, 0, 0);
        step_a(st, mv, mr);
        drive_a(1, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0005, 0, 0, 4'd6, 0);
        step_a(st, mv, mr);
        check("wrap_dm_data", bus_a.out_dm_data, 16'hA5A5);
        check("wrap_result", bus_a.out_result, 16'h0005);

        // Preload 0x0020 with 0, then flush a store in its last BUSY cycle.
        drive_a(1, 0, 0, 1, 0, 16'h0000, 16'h0, 16'h0020, 0, 0, 0, 0);
        step_a(st, mv, mr);
        drive_a(1, 0, 0, 1, 0, 16'h5555, 16'h0, 16'h0020, 0, 0, 0, 0);
        #1; check("fl_stall_idle", bus_a.stall, 1'b1);
        tick();
        #1; check("fl_stall_busy1", bus_a.stall, 1'b1);
        tick();
        bus_a.flush = 1'b1;
        #1; check("fl_stall_flush", bus_a.stall, 1'b0);
        tick();
        bus_a.flush = 1'b0;
        check("fl_bubble_valid", bus_a.out_valid, 1'b0);
        check("fl_bubble_result", bus_a.out_result, 16'h0020);
        drive_a(1, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0020, 0, 0, 4'd7, 0);
        step_a(st, mv, mr);
        check("fl_ld_stalls", st, 2);
        check("fl_ld_dm_data", bus_a.out_dm_data, 16'h0000);

        // Flush of a non-memory op in IDLE yields a bubble.
        drive_a(1, 1, 0, 0, 0, 0, 0, 16'h4321, 0, 0, 4'd2, 0);
        bus_a.flush = 1'b1;
        #1; check("fl_alu_stall", bus_a.stall, 1'b0);
        tick();
        bus_a.flush = 1'b0;
        check("fl_alu_valid", bus_a.out_valid, 1'b0);
        check("fl_alu_rf_write", bus_a.out_rf_write, 1'b0);

        // Store data selection between store data and forwarded data.
`ifdef MEM_STAGE_STORE_FWD_EN
        exp_fwd = 16'h2222;
`else
        exp_fwd = 16'h1111;
`endif
        drive_a(1, 0, 0, 1, 1, 16'h1111, 16'h2222, 16'h0030, 0, 0, 0, 0);
        step_a(st, mv, mr);
        drive_a(1, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0030, 0, 0, 4'd1, 0);
        step_a(st, mv, mr);
        check("fwd_dm_data", bus_a.out_dm_data, exp_fwd);

        // Idle slot: out_valid follows in_valid=0.
        drive_a(0, 0, 0, 0, 0, 0, 0, 16'h0777, 0, 0, 0, 0);
        tick();
        check("idle_valid", bus_a.out_valid, 1'b0);

        // MEM_LAT=1 instance: back-to-back store/load, no stall.
        bus_b.in_valid = 1'b1; bus_b.in_dm_write = 1'b1;
        bus_b.in_store_data = 16'h7777; bus_b.in_result = 16'h0003;
        #1; check("b_st_stall", bus_b.stall, 1'b0);
        tick();
        check("b_st_valid", bus_b.out_valid, 1'b1);
        check("b_st_result", bus_b.out_result, 16'h0003);
        bus_b.in_dm_write = 1'b0; bus_b.in_memtoreg = 1'b1; bus_b.in_rf_write = 1'b1;
        bus_b.in_store_data = 16'h0;
        #1; check("b_ld_stall", bus_b.stall, 1'b0);
        tick();
        check("b_ld_dm_data", bus_b.out_dm_data, 16'h7777);
        check("b_ld_valid", bus_b.out_valid, 1'b1);
        bus_b.in_valid = 1'b0; bus_b.in_memtoreg = 1'b0; bus_b.in_rf_write = 1'b0;

        // rst and flush together: reset clears out_result, flush alone would not.
        drive_a(1, 1, 0, 0, 0, 0, 0, 16'h9999, 0, 0, 4'd4, 0);
        tick();
        check("rf_pre_result", bus_a.out_result, 16'h9999);
        rst = 1'b1;
        bus_a.flush = 1'b1;
        #1; check("rf_stall", bus_a.stall, 1'b0);
        tick();
        check("rf_result", bus_a.out_result, 16'h0);
        check("rf_rd", bus_a.out_rd, 4'h0);
        rst = 1'b0;
        bus_a.flush = 1'b0;
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
